// File: rtl/aes_uart_host.sv
// Host-side initiator for the AES UART coprocessor: sends C/D/E/B frames, collects the response.
// Optional key cache (skips the "C" frame on a repeated key) enabled by AES_UART_HOST_KEY_CACHE_EN.
module aes_uart_host #(
  parameter int unsigned FRAME_BYTES     = 18,
  parameter int unsigned ENC_WAIT_CYCLES = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] text_out,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid
);

  localparam int unsigned WaitW = (ENC_WAIT_CYCLES > 1) ? $clog2(ENC_WAIT_CYCLES) : 1;
  localparam int unsigned ToW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [4:0]       LastIdx  = 5'(FRAME_BYTES - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(ENC_WAIT_CYCLES - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StSendKey, StSendPt, StSendLd, StWaitEnc, StSendRd, StRecv, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     pt_q, pt_d;
  logic [127:0]     res_q, res_d;
  logic [127:0]     text_q, text_d;
  logic             err_q, err_d;

  logic [7:0]   cmd;
  logic [127:0] payload;
  logic [3:0]   byte_sel;
  logic         tx_fire;
  logic         skip_key;

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);
  assign error    = done & err_q;
  assign text_out = text_q;
  assign tx_fire  = tx_valid & tx_ready;

  // Frame bytes are a pure function of state and index, so they stay stable until accepted.
  always_comb begin
    cmd      = 8'h00;
    payload  = '0;
    tx_valid = 1'b0;
    case (state_q)
      StSendKey: begin cmd = 8'h43; payload = key_q; tx_valid = 1'b1; end
      StSendPt:  begin cmd = 8'h44; payload = pt_q;  tx_valid = 1'b1; end
      StSendLd:  begin cmd = 8'h45; tx_valid = 1'b1; end
      StSendRd:  begin cmd = 8'h42; tx_valid = 1'b1; end
      default: ;
    endcase
    // Payload byte k (1..16) is payload byte number 16-k counting from the LSB end.
    byte_sel = 4'd0 - idx_q[3:0];
    if (!tx_valid) begin
      tx_data = 8'h00;
    end else if (idx_q == 5'd0 || idx_q == LastIdx) begin
      tx_data = cmd;
    end else begin
      tx_data = payload[{byte_sel, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    to_d    = to_q;
    key_d   = key_q;
    pt_d    = pt_q;
    res_d   = res_q;
    text_d  = text_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = key;
          pt_d    = text_in;
          idx_d   = 5'd0;
          state_d = skip_key ? StSendPt : StSendKey;
        end
      end
      StSendKey, StSendPt, StSendLd, StSendRd: begin
        if (tx_fire) begin
          if (idx_q == LastIdx) begin
            idx_d  = 5'd0;
            wait_d = '0;
            to_d   = '0;
            case (state_q)
              StSendKey: state_d = StSendPt;
              StSendPt:  state_d = StSendLd;
              StSendLd:  state_d = StWaitEnc;
              default: begin
                state_d = StRecv;
                // A response byte arriving on the entry edge counts as the first pad byte.
                if (rx_valid) idx_d = 5'd1;
              end
            endcase
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      StWaitEnc: begin
        if (wait_q == WaitLast) begin
          state_d = StSendRd;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StRecv: begin
        if (rx_valid) begin
          to_d = '0;
          if (idx_q >= 5'd2) res_d = {res_q[119:0], rx_data};
          if (idx_q == LastIdx) begin
            text_d  = {res_q[119:0], rx_data};
            err_d   = 1'b0;
            idx_d   = 5'd0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end else if (to_q == ToLast) begin
          err_d   = 1'b1;
          idx_d   = 5'd0;
          state_d = StDone;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wait_q  <= '0;
      to_q    <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      res_q   <= '0;
      text_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      res_q   <= res_d;
      text_q  <= text_d;
      err_q   <= err_d;
    end
  end

`ifdef AES_UART_HOST_KEY_CACHE_EN
  logic [127:0] ckey_q, ckey_d;
  logic         cvld_q, cvld_d;

  assign skip_key = cvld_q && (key == ckey_q);

  // Cache is refreshed while sitting in StDone; a start there is ignored anyway.
  always_comb begin
    ckey_d = ckey_q;
    cvld_d = cvld_q;
    if (state_q == StDone) begin
      if (err_q) begin
        cvld_d = 1'b0;
      end else begin
        ckey_d = key_q;
        cvld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ckey_q <= '0;
      cvld_q <= 1'b0;
    end else begin
      ckey_q <= ckey_d;
      cvld_q <= cvld_d;
    end
  end
`else
  assign skip_key = 1'b0;
`endif

endmodule

// File: tb/tb_aes_uart_host.sv
// Directed self-checking bench for aes_uart_host; follows AES_UART_HOST_KEY_CACHE_EN if defined.
module tb_aes_uart_host;

  localparam int unsigned TimeoutCycles = 100;
`ifdef AES_UART_HOST_KEY_CACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  localparam logic [127:0] K0  = 128'h0;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'hf34481ec3cc627bacd5dc3fb08f273e6;
  localparam logic [127:0] CT1 = 128'h0336763e966d92595a567cc9ce537f5e;
  localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h11112222333344445555666677778888;

  logic         clk = 1'b0;
  logic         reset, start, tx_ready, rx_valid;
  logic [127:0] key, text_in;
  logic [7:0]   rx_data;
  logic         busy, done, error, tx_valid;
  logic [127:0] text_out;
  logic [7:0]   tx_data;

  always #5 clk = ~clk;

  aes_uart_host #(
    .FRAME_BYTES    (18),
    .ENC_WAIT_CYCLES(64),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .key     (key),
    .text_in (text_in),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .text_out(text_out),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   txq[$];
  logic [7:0]   exp_q[$];
  logic [7:0]   resp[18];
  bit           got_done, got_err, aborted;
  logic [127:0] got_text;
  int           done_it, rx5_it;
  logic [127:0] cache_key;
  bit           cache_vld;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] cmd, input logic [127:0] pl);
    exp_q.push_back(cmd);
    for (int i = 0; i < 16; i++) exp_q.push_back(pl[127-8*i -: 8]);
    exp_q.push_back(cmd);
  endfunction

  function automatic bit will_skip(input logic [127:0] k);
    return CacheEn && cache_vld && (k == cache_key);
  endfunction

  task automatic check_seq(input string tag);
    check({tag, "_len"}, txq.size(), exp_q.size());
    if (txq.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++)
        check($sformatf("%s_byte%0d", tag, i), txq[i], exp_q[i]);
    end
  endtask

  // Runs one transaction with a responder model; stops on done, on abort, or on the cycle bound.
  task automatic run_txn(input logic [127:0] k, input logic [127:0] p, input logic [127:0] ct,
                         input int n_resp, input bit slow_ready, input int abort_at,
                         input int busy_start_at, input bit start_on_done);
    int         rx_sent, gap;
    bit         held_v, resp_on;
    logic [7:0] held_d;
    exp_q.delete();
    txq.delete();
    if (!will_skip(k)) push_frame(8'h43, k);
    push_frame(8'h44, p);
    push_frame(8'h45, '0);
    push_frame(8'h42, '0);
    for (int i = 0; i < 18; i++) resp[i] = (i < 2) ? 8'h00 : ct[127-8*(i-2) -: 8];
    got_done = 0; aborted = 0; rx_sent = 0; gap = 0; held_v = 0; resp_on = 0;
    held_d = 8'h00; rx5_it = -1; done_it = -1;
    @(negedge clk);
    key = k; text_in = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    for (int it = 0; it < 4000; it++) begin
      if (done) begin
        got_done = 1; got_err = error; got_text = text_out; done_it = it;
        check("busy_low_at_done", busy, 1'b0);
        if (start_on_done) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          check("start_in_done_ignored", {busy, tx_valid}, 2'b00);
        end
        break;
      end
      if (held_v) begin
        check("tx_valid_held", tx_valid, 1'b1);
        check("tx_data_held", tx_data, held_d);
      end
      tx_ready = slow_ready ? (it % 3 == 0) : 1'b1;
      start    = (it == busy_start_at);
      rx_valid = 1'b0;
      if (abort_at >= 0 && tx_valid && txq.size() == abort_at) begin
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0; aborted = 1;
        break;
      end
      held_v = tx_valid && !tx_ready;
      held_d = tx_data;
      if (tx_valid && tx_ready) begin
        txq.push_back(tx_data);
        if (tx_data == 8'h42 && txq.size() % 18 == 0) resp_on = 1;
      end
      if (resp_on && rx_sent < n_resp) begin
        if (gap == 2) begin
          rx_valid = 1'b1; rx_data = resp[rx_sent]; rx_sent++; gap = 0;
          if (rx_sent == 5) rx5_it = it;
        end else begin
          gap++;
        end
      end
      @(negedge clk);
    end
    start = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
    if (!aborted) check("done_within_bound", got_done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int abort_at;
    cache_key = '0; cache_vld = 0;
    reset = 1'b1; start = 1'b0; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    key = '0; text_in = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {busy, done, error, tx_valid, tx_data}, 12'h000);
    check("rst_text_out", text_out, 128'h0);
    reset = 1'b0;

    // Basic encryption.
    run_txn(K0, PT, CT1, 18, 1'b0, -1, -1, 1'b0);
    check("t1_len", txq.size(), 72);
    check("t1_b0", txq[0], 8'h43);
    check("t1_b17", txq[17], 8'h43);
    check("t1_b19", txq[19], 8'hf3);
    check("t1_b54", txq[54], 8'h42);
    check_seq("t1");
    check("t1_err", got_err, 1'b0);
    check("t1_text", got_text, CT1);
    cache_key = K0; cache_vld = 1;

    // Backpressure, start while busy, start in the done cycle.
    run_txn(K0, PT, CT1, 18, 1'b1, -1, 40, 1'b1);
    check_seq("t2");
    check("t2_b0", txq[0], CacheEn ? 8'h44 : 8'h43);
    check("t2_err", got_err, 1'b0);
    check("t2_text", got_text, CT1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t2_no_second_txn", {busy, done}, 2'b00);
    end

    // Response timeout after 5 bytes.
    run_txn(K0, PT, CT3, 5, 1'b0, -1, -1, 1'b0);
    check("t3_err", got_err, 1'b1);
    check("t3_text_kept", got_text, CT1);
    check("t3_timeout_gap", done_it - rx5_it, 101);
    @(negedge clk);
    check("t3_idle_after", {busy, done, error}, 3'b000);
    cache_vld = 0;

    // After an error the key frame must be resent.
    run_txn(K0, PT, CT2, 18, 1'b0, -1, -1, 1'b0);
    check("t4_b0", txq[0], 8'h43);
    check_seq("t4");
    check("t4_err", got_err, 1'b0);
    check("t4_text", got_text, CT2);
    cache_key = K0; cache_vld = 1;

    // Reset during byte 9 of the "D" frame.
    abort_at = (will_skip(K2) ? 0 : 18) + 9;
    run_txn(K2, PT, CT1, 18, 1'b0, abort_at, -1, 1'b0);
    check("t5_aborted", aborted, 1'b1);
    check("t5_outputs", {busy, done, error, tx_valid, tx_data}, 12'h000);
    check("t5_text_out", text_out, 128'h0);
    cache_vld = 0;

    // Stray response bytes while idle.
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'ha5 + 8'(i);
      @(negedge clk);
      check("stray_idle", {busy, done, tx_valid}, 3'b000);
    end
    rx_valid = 1'b0;
    check("stray_text_out", text_out, 128'h0);

    run_txn(K2, PT, CT2, 18, 1'b0, -1, -1, 1'b0);
    check("t6_b0", txq[0], 8'h43);
    check_seq("t6");
    check("t6_err", got_err, 1'b0);
    check("t6_text", got_text, CT2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
